// File: rtl/hb_data_ram_arbiter_pkg.sv
// Shared types and helpers for the data-RAM arbiter.
package hb_data_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RWAIT = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
  } hb_mreq_t;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

  // Width 11 is never legal; half and word accesses must be naturally aligned.
  function automatic logic is_illegal(input logic [1:0] width, input logic [1:0] addr_lo);
    return (width == 2'b11) ||
           ((width == W_HALF) && addr_lo[0]) ||
           ((width == W_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/hb_data_ram_arbiter_rr.sv
// Two-way round-robin pick with a registered last-grant pointer.
module hb_rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  input  logic       i_upd_idx,
  output logic       o_vld,
  output logic       o_idx
);
  logic r_last;

  // Remember who was served last; reset value makes M0 win the first tie.
  always_ff @(posedge i_clk) begin
    if (i_rst)      r_last <= 1'b1;
    else if (i_upd) r_last <= i_upd_idx;
  end

  // Single requester wins outright; on a tie the master not served last wins.
  always_comb begin
    o_vld = |i_req;
    o_idx = 1'b0;
    if (i_req == 2'b11) o_idx = ~r_last;
    else                o_idx = i_req[1];
  end
endmodule

// File: rtl/hb_data_ram_arbiter.sv
// Two-master arbiter and access sequencer for the data-RAM port.
module hb_data_ram_arbiter
  import hb_data_ram_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic            hb_clk,
  input  logic            hb_rst,
  input  logic [1:0]      m_req,
  input  logic [1:0]      m_we,
  input  logic [1:0][31:0] m_addr,
  input  logic [1:0][31:0] m_wdata,
  input  logic [1:0][1:0] m_width,
  output logic [1:0]      m_done,
  output logic [1:0]      m_err,
  output logic [31:0]     m_rdata,
  output logic            busy,
  output logic            ram_ren,
  output logic            ram_wen,
  output logic [31:0]     ram_raddr,
  output logic [31:0]     ram_waddr,
  output logic [31:0]     ram_wdata,
  output logic [1:0]      ram_write_width,
  input  logic [31:0]     ram_rdata,
  input  logic            ram_read_finish,
  input  logic            ram_write_finish
);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

  arb_state_e       r_state, w_state_nxt;
  hb_mreq_t         r_req, w_win_req;
  logic             r_idx, r_err, w_err_nxt;
  logic [31:0]      r_rdata;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [1:0]       r_mask, w_elig;
  logic             w_arb_vld, w_arb_idx, w_latch, w_cap, w_upd, w_fin, w_bad;

  // A master whose done pulse just went out is ignored for one cycle so a
  // late-dropped request is not granted twice.
  assign w_elig    = m_req & ~r_mask;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_fin     = r_req.we ? ram_write_finish : ram_read_finish;

  hb_rr_arbiter2 u_rr (
    .i_clk     (hb_clk),
    .i_rst     (hb_rst),
    .i_req     (w_elig),
    .i_upd     (w_upd),
    .i_upd_idx (r_idx),
    .o_vld     (w_arb_vld),
    .o_idx     (w_arb_idx)
  );

  // Winner's request as it will be latched; the legality check looks at
  // exactly these bits so a rejected access reaches RESP one cycle later.
  always_comb begin
    w_win_req.we    = m_we[w_arb_idx];
    w_win_req.addr  = m_addr[w_arb_idx];
    w_win_req.wdata = m_wdata[w_arb_idx];
    w_win_req.width = m_width[w_arb_idx];
    w_bad           = is_illegal(w_win_req.width, w_win_req.addr[1:0]);
  end

  // State register.
  always_ff @(posedge hb_clk) begin
    if (hb_rst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and datapath control.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_cap       = 1'b0;
    w_upd       = 1'b0;
    w_err_nxt   = r_err;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_arb_vld) begin
          w_latch     = 1'b1;
          w_err_nxt   = w_bad;
          w_state_nxt = w_bad ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        w_cnt_nxt = '0;
        // A read finish here cannot be legal (the RAM registers it), so only
        // the write path looks at the finish in this cycle.
        if (r_req.we && ram_write_finish) w_state_nxt = RESP;
        else                              w_state_nxt = RWAIT;
      end
      RWAIT: begin
        if (w_fin) begin
          w_cap       = ~r_req.we;
          w_state_nxt = RESP;
        end else if (w_cnt_inc == TO_LIM) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      RESP: begin
        w_upd       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request latch, result, timeout counter and one-cycle done mask.
  always_ff @(posedge hb_clk) begin
    if (hb_rst) begin
      r_req   <= '0;
      r_idx   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_mask  <= '0;
    end else begin
      r_err  <= w_err_nxt;
      r_cnt  <= w_cnt_nxt;
      r_mask <= m_done;
      if (w_latch) begin
        r_req   <= w_win_req;
        r_idx   <= w_arb_idx;
        r_rdata <= '0;
      end else if (w_cap) begin
        r_rdata <= ram_rdata;
      end
    end
  end

  // Master-side response, only meaningful in RESP.
  always_comb begin
    m_done  = 2'b00;
    m_err   = 2'b00;
    m_rdata = '0;
    if (r_state == RESP) begin
      m_done[r_idx] = 1'b1;
      m_err[r_idx]  = r_err;
      m_rdata       = r_rdata;
    end
  end

  assign busy            = (r_state != IDLE);
  assign ram_ren         = (r_state == ISSUE) && !r_req.we;
  assign ram_wen         = (r_state == ISSUE) &&  r_req.we;
  assign ram_raddr       = r_req.addr;
  assign ram_waddr       = r_req.addr;
  assign ram_wdata       = r_req.wdata;
  assign ram_write_width = r_req.width;

endmodule

// File: tb/tb_hb_data_ram_arbiter.sv
// Bench for hb_data_ram_arbiter: transaction-level timing model plus literal pins.
module tb_hb_data_ram_arbiter;
  import hb_data_ram_arbiter_pkg::*;
  localparam int TO = 15;

  logic             hb_clk = 1'b0;
  logic             hb_rst = 1'b1;
  logic [1:0]       m_req = '0, m_we = '0;
  logic [1:0][31:0] m_addr = '0, m_wdata = '0;
  logic [1:0][1:0]  m_width = '0;
  logic [1:0]       m_done, m_err;
  logic [31:0]      m_rdata, ram_raddr, ram_waddr, ram_wdata;
  logic             busy, ram_ren, ram_wen;
  logic [1:0]       ram_write_width;
  logic [31:0]      ram_rdata = '0;
  logic             ram_read_finish = 1'b0, ram_write_finish = 1'b0;

  hb_data_ram_arbiter dut (
    .hb_clk(hb_clk), .hb_rst(hb_rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_width(m_width), .m_done(m_done), .m_err(m_err),
    .m_rdata(m_rdata), .busy(busy), .ram_ren(ram_ren), .ram_wen(ram_wen),
    .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_write_width(ram_write_width), .ram_rdata(ram_rdata),
    .ram_read_finish(ram_read_finish), .ram_write_finish(ram_write_finish)
  );

  always #5 hb_clk = ~hb_clk;

  int cyc = 0;
  int n_chk = 0, n_err = 0;
  int cfg_rd_dly = 1, cfg_wr_dly = 0;   // 0 for reads = never finish
  int rd_fire = -1, wr_fire = -1;
  int p_rst = 0, p_wr = -100, p_rd = -100, p_both = -100, p_mis = -100, p_to = -100, p_b2 = -100;

  // Model: one outstanding transaction described by grant cycle, done cycle, result.
  bit          mb = 1'b0, t_leg, t_we, t_err;
  int          g, t_done, t_idx, last = 1, d, sz;
  logic [1:0]  mmask = '0, m_el;
  logic [31:0] t_rd, t_addr, t_wd;
  logic [1:0]  t_w;

  always @(posedge hb_clk) begin
    if (hb_rst) begin
      mb = 1'b0; last = 1; mmask = '0;
    end else if (mb) begin
      if (cyc == t_done - 1 && !t_we) t_rd = ram_rdata;
      if (cyc == t_done) begin
        mb = 1'b0; last = t_idx; mmask = (t_idx == 1) ? 2'b10 : 2'b01;
      end
    end else begin
      m_el = m_req & ~mmask;
      mmask = '0;
      if (m_el != 2'b00) begin
        t_idx = (m_el == 2'b11) ? 1 - last : (m_el[1] ? 1 : 0);
        t_we = m_we[t_idx]; t_addr = m_addr[t_idx]; t_wd = m_wdata[t_idx]; t_w = m_width[t_idx];
        sz = 1 << t_w;
        t_leg = (t_w != 2'b11) && ((int'(t_addr[1:0]) % sz) == 0);
        g = cyc; mb = 1'b1; t_rd = '0;
        if (!t_leg) begin
          t_err = 1'b1; t_done = cyc + 1;
        end else begin
          d = t_we ? cfg_wr_dly : cfg_rd_dly;
          if ((!t_we && d == 0) || d > TO) begin t_err = 1'b1; t_done = cyc + 2 + TO; end
          else begin t_err = 1'b0; t_done = cyc + 2 + d; end
        end
      end
    end
    cyc = cyc + 1;
  end

  // RAM responder: finish pulses a configured number of cycles after the strobe.
  always @(posedge hb_clk) begin
    #1;
    ram_read_finish  = (cyc == rd_fire);
    ram_write_finish = (cfg_wr_dly == 0) || (cyc == wr_fire);
    if (ram_ren) rd_fire = (cfg_rd_dly > 0) ? cyc + cfg_rd_dly : -1;
    if (ram_wen && cfg_wr_dly > 0) wr_fire = cyc + cfg_wr_dly;
  end

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  logic        e_iss, e_fin;
  logic [1:0]  e_done, e_err;
  logic [31:0] e_rd;

  // Compare process: model every cycle, plus hand-computed pins.
  always @(negedge hb_clk) begin
    e_iss  = mb && t_leg && (cyc == g + 1);
    e_fin  = mb && (cyc == t_done);
    e_done = e_fin ? ((t_idx == 1) ? 2'b10 : 2'b01) : 2'b00;
    e_err  = (e_fin && t_err) ? e_done : 2'b00;
    e_rd   = (e_fin && !t_we && !t_err) ? t_rd : 32'h0;
    chk("ctl", 72'({busy, ram_ren, ram_wen, m_done, m_err}),
               72'({mb, e_iss && !t_we, e_iss && t_we, e_done, e_err}));
    chk("rdata", 72'(m_rdata), 72'(e_rd));
    if (e_iss)
      chk("ram_req", 72'({t_we ? ram_waddr : ram_raddr, ram_wdata, ram_write_width}),
                     72'({t_addr, t_wd, t_w}));
    if (cyc == p_rst + 1) begin
      chk("rst_ctl", 72'({busy, ram_ren, ram_wen, m_done, m_err, m_rdata}), 72'(0));
      chk("rst_ram", 72'({ram_raddr, ram_waddr}), 72'(0));
      chk("rst_wd",  72'({ram_wdata, ram_write_width}), 72'(0));
    end
    if (cyc == p_wr + 1) chk("wr_issue", 72'({ram_wen, ram_waddr, ram_wdata}), 72'({1'b1, 32'h100, 32'hDEADBEEF}));
    if (cyc == p_wr + 2) chk("wr_done", 72'({m_done, m_err}), 72'(4'b0100));
    if (cyc == p_rd + 1) chk("rd_issue", 72'({ram_ren, ram_raddr}), 72'({1'b1, 32'h103}));
    if (cyc == p_rd + 2) chk("rd_wait", 72'({busy, m_done}), 72'(3'b100));
    if (cyc == p_rd + 3) chk("rd_done", 72'({m_done, m_err, m_rdata}), 72'({2'b10, 2'b00, 32'hA5}));
    if (cyc == p_both + 1) chk("rr_first_m0", 72'({ram_wen, ram_ren}), 72'(2'b10));
    if (cyc == p_both + 4) chk("rr_then_m1", 72'({ram_wen, ram_ren, ram_raddr}), 72'({2'b01, 32'h204}));
    if (cyc == p_both + 8) chk("rr_back_m0", 72'({ram_wen, ram_ren}), 72'(2'b10));
    if (cyc == p_mis + 1) chk("misalign", 72'({ram_wen, ram_ren, m_done, m_err}), 72'(6'b000101));
    if (cyc == p_to + 16) chk("to_pending", 72'({busy, m_done}), 72'(3'b100));
    if (cyc == p_to + 17) chk("to_done", 72'({m_done, m_err, m_rdata}), 72'({2'b01, 2'b01, 32'h0}));
    if (cyc == p_to + 18) chk("to_idle", 72'(busy), 72'(0));
    if (cyc == p_b2 + 1) chk("post_rst_m0", 72'({ram_wen, ram_ren, ram_raddr}), 72'({2'b01, 32'h10}));
  end

  task automatic setm(input int m, input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] w);
    m_we[m] = we; m_addr[m] = a; m_wdata[m] = wd; m_width[m] = w; m_req[m] = 1'b1;
  endtask

  // Hold requests until done; a master with repeats left keeps its request up.
  task automatic serve(input int r0, input int r1, input int budget);
    int n = 0;
    int r[2];
    r[0] = r0; r[1] = r1;
    while (m_req != 2'b00) begin
      @(negedge hb_clk);
      n++;
      for (int m = 0; m < 2; m++)
        if (m_done[m]) begin
          if (r[m] > 0) r[m]--;
          else          m_req[m] = 1'b0;
        end
      if (n > budget) begin
        $display("FAIL serve_budget: req %b still pending after %0d cycles", m_req, n);
        $fatal(1, "stalled");
      end
    end
    repeat (2) @(negedge hb_clk);
  endtask

  initial begin
    repeat (3) @(negedge hb_clk);
    hb_rst = 1'b0;
    @(negedge hb_clk);
    // word write, immediate finish
    setm(0, 1, 32'h100, 32'hDEADBEEF, W_WORD); p_wr = cyc; serve(0, 0, 20);
    // byte read, finish one cycle after ren
    ram_rdata = 32'hA5;
    setm(1, 0, 32'h103, 32'h0, W_BYTE); p_rd = cyc; serve(0, 0, 20);
    // simultaneous requests from reset, M0 repeats once: M0, M1, M0
    hb_rst = 1'b1; p_rst = cyc; @(negedge hb_clk); hb_rst = 1'b0; @(negedge hb_clk);
    setm(0, 1, 32'h200, 32'h11223344, W_WORD);
    setm(1, 0, 32'h204, 32'h0, W_WORD);
    p_both = cyc; serve(1, 0, 40);
    // rejected accesses
    setm(0, 1, 32'h101, 32'h1234, W_HALF); p_mis = cyc; serve(0, 0, 20);
    setm(0, 1, 32'h100, 32'h55, 2'b11); serve(0, 0, 20);
    setm(1, 0, 32'h102, 32'h0, W_WORD); serve(0, 0, 20);
    setm(1, 1, 32'h102, 32'hBEEF, W_HALF); serve(0, 0, 20);
    // read timeout, then a late finish landing in IDLE
    cfg_rd_dly = 0; ram_rdata = 32'h12345678;
    setm(0, 0, 32'h40, 32'h0, W_WORD); p_to = cyc; serve(0, 0, 40);
    cfg_rd_dly = TO + 2;
    setm(1, 0, 32'h44, 32'h0, W_HALF); serve(0, 0, 40);
    repeat (3) @(negedge hb_clk);
    // delayed write finish, and a read finishing exactly at the limit
    cfg_rd_dly = 1; cfg_wr_dly = 2;
    setm(1, 1, 32'h302, 32'hBEEF, W_HALF); serve(0, 0, 20);
    cfg_wr_dly = 0; cfg_rd_dly = TO; ram_rdata = 32'hCAFE0001;
    setm(0, 0, 32'h80, 32'h0, W_BYTE); serve(0, 0, 40);
    // reset while waiting on a read; pointer must return to M0
    cfg_rd_dly = 0;
    setm(1, 0, 32'h90, 32'h0, W_WORD);
    repeat (4) @(negedge hb_clk);
    hb_rst = 1'b1; m_req = 2'b00; p_rst = cyc;
    @(negedge hb_clk); hb_rst = 1'b0; @(negedge hb_clk);
    cfg_rd_dly = 1;
    setm(0, 0, 32'h10, 32'h0, W_WORD);
    setm(1, 1, 32'h20, 32'h77, W_WORD);
    p_b2 = cyc; serve(0, 0, 30);
    repeat (3) @(negedge hb_clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
